// File: rtl/sevenseg_scheduler_pkg.sv
// Shared types and constants for the 8-digit multiplexed seven-segment scheduler.
// The optional brightness feature is enabled with SEVENSEG_BRIGHTNESS_EN.
package peripherals;

  localparam int         SEVENSEG_NUM_DIGITS = 8;
  localparam logic [7:0] SEVENSEG_OFF        = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    BLANK = 2'd2
  } sevenseg_state_t;

  typedef struct packed {
    logic [31:0] digits;
    logic [7:0]  enable;
    logic [7:0]  dp;
  } sevenseg_frame_t;

  // Lit cycles per drive phase: ceil((level+1) * digit_cycles / 8).
  function automatic int sevenseg_lit_cycles(input logic [2:0] level, input int digit_cycles);
    return ((int'(level) + 1) * digit_cycles + 7) / 8;
  endfunction

endpackage

// File: rtl/sevenseg_scheduler_decoder.sv
// Combinational hex nibble to active-low seven-segment glyph, bits {g,f,e,d,c,b,a}.
module sevenseg_decoder (
  input  logic [3:0] nibble,
  output logic [6:0] segments
);

  always_comb begin
    case (nibble)
      4'h0:    segments = 7'h40;
      4'h1:    segments = 7'h79;
      4'h2:    segments = 7'h24;
      4'h3:    segments = 7'h30;
      4'h4:    segments = 7'h19;
      4'h5:    segments = 7'h12;
      4'h6:    segments = 7'h02;
      4'h7:    segments = 7'h78;
      4'h8:    segments = 7'h00;
      4'h9:    segments = 7'h10;
      4'hA:    segments = 7'h08;
      4'hB:    segments = 7'h03;
      4'hC:    segments = 7'h46;
      4'hD:    segments = 7'h21;
      4'hE:    segments = 7'h06;
      default: segments = 7'h0E;
    endcase
  end

endmodule

// File: rtl/sevenseg_scheduler.sv
// Time-multiplexed 8-digit seven-segment driver with double-buffered frame loading.
// Define SEVENSEG_BRIGHTNESS_EN to enable per-slot duty control from the brightness input.
module sevenseg_scheduler
  import peripherals::*;
#(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clock_100mhz,
  input  logic        reset,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_digits,
  input  logic [7:0]  load_enable,
  input  logic [7:0]  load_dp,
  input  logic [2:0]  brightness,
  output logic [7:0]  sevenseg_anode,
  output logic [7:0]  sevenseg_cathode,
  output logic        frame_start
);

  localparam int MAX_CYCLES = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  // One extra bit of headroom so the counter width can also hold DIGIT_CYCLES itself.
  localparam int CW = (MAX_CYCLES < 1) ? 1 : $clog2(MAX_CYCLES + 1);
  localparam int DW = $clog2(SEVENSEG_NUM_DIGITS);

  localparam logic [CW-1:0] DRIVE_LAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [DW-1:0] DIGIT_LAST = DW'(SEVENSEG_NUM_DIGITS - 1);

  sevenseg_state_t state_q, state_d;
  logic [DW-1:0]   digit_q, digit_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            drive_entry;
  logic            boundary;

  sevenseg_frame_t active_q, active_d;
  sevenseg_frame_t pending_q, pending_d;
  logic            pending_flag_q, pending_flag_d;
  sevenseg_frame_t load_frame;
  logic            load_accept;

  logic [7:0] anode_d, cathode_d;
  logic [7:0] anode_q, cathode_q;
  logic       frame_start_d, frame_start_q;
  logic       bright_ok;
  logic       lit;
  logic [3:0] nibble;
  logic [6:0] segments;

  // Slot sequencer. Everything downstream is computed from the *next* state so the
  // registered outputs line up with the state register and show no extra latency.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    digit_d     = digit_q;
    cnt_d       = cnt_q;
    drive_entry = 1'b0;
    boundary    = 1'b0;
    case (state_q)
      IDLE: begin
        state_d     = DRIVE;
        digit_d     = '0;
        cnt_d       = '0;
        drive_entry = 1'b1;
      end
      DRIVE: begin
        if (cnt_q == DRIVE_LAST) begin
          state_d = BLANK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d     = DRIVE;
          cnt_d       = '0;
          digit_d     = digit_q + DW'(1);
          drive_entry = 1'b1;
          boundary    = (digit_q == DIGIT_LAST);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        digit_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Frame buffering: loads park in pending and are promoted only at the frame
  // boundary, so the displayed frame never tears. A load landing exactly on the
  // boundary goes straight to active for the frame that is starting.
  assign load_frame  = '{digits: load_digits, enable: load_enable, dp: load_dp};
  assign load_accept = load_valid & ~pending_flag_q;

  always_comb begin
    active_d       = active_q;
    pending_d      = pending_q;
    pending_flag_d = pending_flag_q;
    if (boundary) begin
      if (pending_flag_q) begin
        active_d       = pending_q;
        pending_flag_d = 1'b0;
      end else if (load_accept) begin
        active_d = load_frame;
      end
    end else if (load_accept) begin
      pending_d      = load_frame;
      pending_flag_d = 1'b1;
    end
  end

`ifdef SEVENSEG_BRIGHTNESS_EN
  // Duty limit is captured at each drive entry and held for the whole phase.
  logic [CW-1:0] lit_limit_q, lit_limit_d;

  always_comb begin
    lit_limit_d = lit_limit_q;
    if (drive_entry) lit_limit_d = CW'(sevenseg_lit_cycles(brightness, DIGIT_CYCLES));
  end

  always_ff @(posedge clock_100mhz) begin
    if (reset) lit_limit_q <= '0;
    else       lit_limit_q <= lit_limit_d;
  end

  assign bright_ok = (cnt_d < lit_limit_d);
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
  assign bright_ok         = 1'b1;
`endif

  assign nibble = active_d.digits[{digit_d, 2'b00} +: 4];

  sevenseg_decoder u_decoder (
    .nibble   (nibble),
    .segments (segments)
  );

  always_comb begin
    lit           = (state_d == DRIVE) && active_d.enable[digit_d] && bright_ok;
    anode_d       = SEVENSEG_OFF;
    cathode_d     = SEVENSEG_OFF;
    frame_start_d = drive_entry && (digit_d == '0);
    if (lit) begin
      anode_d   = ~(8'b1 << digit_d);
      cathode_d = {~active_d.dp[digit_d], segments};
    end
  end

  always_ff @(posedge clock_100mhz) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q        <= IDLE;
      digit_q        <= '0;
      cnt_q          <= '0;
      active_q       <= '0;
      pending_q      <= '0;
      pending_flag_q <= 1'b0;
      anode_q        <= SEVENSEG_OFF;
      cathode_q      <= SEVENSEG_OFF;
      frame_start_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      digit_q        <= digit_d;
      cnt_q          <= cnt_d;
      active_q       <= active_d;
      pending_q      <= pending_d;
      pending_flag_q <= pending_flag_d;
      anode_q        <= anode_d;
      cathode_q      <= cathode_d;
      frame_start_q  <= frame_start_d;
    end
  end

  assign load_ready       = ~pending_flag_q;
  assign sevenseg_anode   = anode_q;
  assign sevenseg_cathode = cathode_q;
  assign frame_start      = frame_start_q;

endmodule

// File: tb/tb_sevenseg_scheduler.sv
// Directed bench for sevenseg_scheduler with DIGIT_CYCLES=4, BLANK_CYCLES=2 (48-cycle frame).
module tb_sevenseg_scheduler;

  logic        clock_100mhz = 1'b0;
  logic        reset        = 1'b1;
  logic        load_valid   = 1'b0;
  logic        load_ready;
  logic [31:0] load_digits  = '0;
  logic [7:0]  load_enable  = '0;
  logic [7:0]  load_dp      = '0;
  logic [2:0]  brightness   = 3'd7;
  logic [7:0]  sevenseg_anode;
  logic [7:0]  sevenseg_cathode;
  logic        frame_start;

  int total = 0;
  int bad   = 0;

  sevenseg_scheduler #(
    .DIGIT_CYCLES (4),
    .BLANK_CYCLES (2)
  ) dut (
    .clock_100mhz     (clock_100mhz),
    .reset            (reset),
    .load_valid       (load_valid),
    .load_ready       (load_ready),
    .load_digits      (load_digits),
    .load_enable      (load_enable),
    .load_dp          (load_dp),
    .brightness       (brightness),
    .sevenseg_anode   (sevenseg_anode),
    .sevenseg_cathode (sevenseg_cathode),
    .frame_start      (frame_start)
  );

  always #5 clock_100mhz = ~clock_100mhz;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clock_100mhz);
  endtask

  // Steps until frame_start is seen; returns how many cycles that took.
  task automatic wait_frame(input string tag, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!frame_start && n < 200);
    check({tag, "_fs_seen"}, 32'(frame_start), 32'd1);
  endtask

  task automatic offer(input logic [31:0] d, input logic [7:0] en, input logic [7:0] dp);
    load_valid  = 1'b1;
    load_digits = d;
    load_enable = en;
    load_dp     = dp;
  endtask

  // Active-low glyphs for 0..7, written out by hand.
  function automatic logic [6:0] glyph(input int i);
    logic [6:0] t [8];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
    return t[i];
  endfunction

  initial begin
    int n;
    int dark;
    int lit_cnt;
    int exp_lit;

    // Reset state
    step(3);
    check("rst_anode", 32'(sevenseg_anode), 32'hFF);
    check("rst_cathode", 32'(sevenseg_cathode), 32'hFF);
    check("rst_ready", 32'(load_ready), 32'd1);
    check("rst_fs", 32'(frame_start), 32'd0);

    // First drive cycle after release, then the dark 48-cycle frame period
    reset = 1'b0;
    step();
    check("fs_first", 32'(frame_start), 32'd1);
    check("dark_first_anode", 32'(sevenseg_anode), 32'hFF);
    n = 0;
    dark = 0;
    do begin
      step();
      n++;
      if (sevenseg_anode != 8'hFF || sevenseg_cathode != 8'hFF) dark++;
    end while (!frame_start && n < 200);
    check("frame_period", 32'(n), 32'd48);
    check("dark_frame", 32'(dark), 32'd0);

    // Load A mid-frame; shows from the next frame
    offer(32'h7654_3210, 8'hFF, 8'h01);
    step();
    load_valid = 1'b0;
    check("a_ready_low", 32'(load_ready), 32'd0);
    wait_frame("a", n);
    check("a_ready_back", 32'(load_ready), 32'd1);
    check("a_d0_anode", 32'(sevenseg_anode), 32'hFE);
    check("a_d0_cathode", 32'(sevenseg_cathode), 32'h40);
    for (int k = 1; k < 4; k++) begin
      step();
      check($sformatf("a_d0_drive%0d", k), {sevenseg_anode, sevenseg_cathode}, 16'hFE40);
    end
    for (int k = 0; k < 2; k++) begin
      step();
      check($sformatf("a_d0_blank%0d", k), {sevenseg_anode, sevenseg_cathode}, 16'hFFFF);
    end
    step();
    check("a_d1", {sevenseg_anode, sevenseg_cathode}, 16'hFDF9);

    // Load B mid-frame, then hold a third load C while B is pending
    offer(32'h8000_0000, 8'h80, 8'h00);
    step();
    offer(32'h0000_000A, 8'h01, 8'h01);
    check("b_ready_low", 32'(load_ready), 32'd0);
    step(5);
    for (int i = 2; i < 8; i++) begin
      check($sformatf("a_intact_d%0d", i), {sevenseg_anode, sevenseg_cathode},
            {~(8'b1 << i), 1'b1, glyph(i)});
      check($sformatf("c_held_d%0d", i), 32'(load_ready), 32'd0);
      step(6);
    end
    check("b_fs", 32'(frame_start), 32'd1);
    check("b_d0_dark", {sevenseg_anode, sevenseg_cathode}, 16'hFFFF);
    check("b_ready_boundary", 32'(load_ready), 32'd1);
    step();
    load_valid = 1'b0;
    check("c_pending", 32'(load_ready), 32'd0);
    dark = 0;
    if (sevenseg_anode != 8'hFF || sevenseg_cathode != 8'hFF) dark++;
    for (int k = 0; k < 40; k++) begin
      step();
      if (sevenseg_anode != 8'hFF || sevenseg_cathode != 8'hFF) dark++;
    end
    check("b_d0_6_dark", 32'(dark), 32'd0);
    step();
    check("b_d7", {sevenseg_anode, sevenseg_cathode}, 16'h7F80);
    wait_frame("c", n);
    check("c_d0", {sevenseg_anode, sevenseg_cathode}, 16'hFE08);

    // Load D exactly on the boundary cycle (BLANK of digit 7, last count)
    step(47);
    check("d_pre_boundary_fs", 32'(frame_start), 32'd0);
    offer(32'h0000_0005, 8'h01, 8'h00);
    step();
    load_valid = 1'b0;
    check("d_fs", 32'(frame_start), 32'd1);
    check("d_bypass", {sevenseg_anode, sevenseg_cathode}, 16'hFE92);
    check("d_ready", 32'(load_ready), 32'd1);

    // Load E (digit 3 lit), then reset in the middle of digit 3's drive
    offer(32'h0000_3000, 8'h08, 8'h00);
    step();
    load_valid = 1'b0;
    wait_frame("e", n);
    step(18);
    check("e_d3", {sevenseg_anode, sevenseg_cathode}, 16'hF7B0);
    step();
    reset = 1'b1;
    offer(32'h0000_3000, 8'h08, 8'h00);
    step();
    check("rst_mid_dark", {sevenseg_anode, sevenseg_cathode}, 16'hFFFF);
    check("rst_mid_fs", 32'(frame_start), 32'd0);
    check("rst_mid_ready", 32'(load_ready), 32'd1);
    reset = 1'b0;
    load_valid = 1'b0;
    step();
    check("rst_restart_fs", 32'(frame_start), 32'd1);
    step(18);
    check("rst_active_cleared", {sevenseg_anode, sevenseg_cathode}, 16'hFFFF);

    // Brightness 1: one of four drive cycles lit with the feature, all four without it
    brightness = 3'd1;
    offer(32'h0000_0000, 8'h01, 8'h00);
    step();
    load_valid = 1'b0;
    wait_frame("f", n);
`ifdef SEVENSEG_BRIGHTNESS_EN
    exp_lit = 1;
`else
    exp_lit = 4;
`endif
    lit_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      if (sevenseg_anode == 8'hFE && sevenseg_cathode == 8'hC0) lit_cnt++;
    end
    check("f_lit_cycles", 32'(lit_cnt), 32'(exp_lit));
    step();
    check("f_blank", {sevenseg_anode, sevenseg_cathode}, 16'hFFFF);
    step();
    check("f_d1_dark", {sevenseg_anode, sevenseg_cathode}, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
